pipelined_alu_dp: RTL and testbench

Parametrised two-stage pipelined ALU datapath. It decodes a one-hot function code, executes one of eight arithmetic/logic operations on WIDTH-bit operands, and registers the result with carry, zero, parity and error flags. Valid/ready handshakes on both sides allow back-pressure without losing data. It replaces the fixed 4-bit, always-advancing ALU pipeline in the lab datapath.

---
 rtl/pipelined_alu_dp.sv | 92 +++++++++
 tb/tb_pipelined_alu_dp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_dp.sv
// pipelined_alu_dp: two-stage valid/ready ALU (one-hot func_code; a/b in; out_result plus carry/zero/parity/err flags out)
module pipelined_alu_dp #(
  parameter int WIDTH      = 4,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       func_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_err
);
  logic             s1_valid, s1_err, err, s1_load, s2_load;
  logic [2:0]       op, s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH:0]   res;
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  always_comb begin
    op  = 3'd0;
    err = 1'b0;
    case (func_code)
      8'h80: op = 3'd0;
      8'h40: op = 3'd1;
      8'h20: op = 3'd2;
      8'h10: op = 3'd3;
      8'h08: op = 3'd4;
      8'h04: op = 3'd5;
      8'h02: op = 3'd6;
      8'h01: op = 3'd7;
      default: err = 1'b1;
    endcase
  end
  always_comb begin
    res = {1'b0, s1_a};
    if (!s1_err)
      case (s1_op)
        3'd0: res = {1'b0, s1_a} + {1'b0, s1_b};
        3'd1: res = {1'b0, s1_a} - {1'b0, s1_b};
        3'd2: res = {1'b0, s1_a ^ s1_b};
        3'd3: res = {1'b0, s1_a | s1_b};
        3'd4: res = {1'b0, s1_a & s1_b};
        3'd5: res = {1'b0, ~(s1_a | s1_b)};
        3'd6: res = {1'b0, ~(s1_a & s1_b)};
        default: res = {1'b0, ~(s1_a ^ s1_b)};
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_err     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= op;
          s1_err <= err;
          s1_a   <= a;
          s1_b   <= b;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res[WIDTH-1:0];
          out_carry  <= res[WIDTH];
          out_zero   <= res[WIDTH-1:0] == '0;
          out_parity <= PARITY_ODD ? ~^res[WIDTH-1:0] : ^res[WIDTH-1:0];
          out_err    <= s1_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_alu_dp.sv
// tb_pipelined_alu_dp: scoreboard bench for pipelined_alu_dp (4-bit odd, 4-bit even and 8-bit builds)
module tb_pipelined_alu_dp;
  typedef struct {logic [7:0] r; logic c, z, p, e;} exp_t;
  logic clk = 0, rst_n, in_valid, out_ready;
  logic [7:0] func_code, a8, b8;
  logic [3:0] a, b;
  logic in_ready, out_valid, out_carry, out_zero, out_parity, out_err;
  logic [3:0] out_result;
  logic p_in_ready, p_out_valid, p_out_carry, p_out_zero, p_out_parity, p_out_err;
  logic [3:0] p_out_result;
  logic w_in_ready, w_out_valid, w_out_carry, w_out_zero, w_out_parity, w_out_err;
  logic [7:0] w_out_result;
  exp_t q[$], q8[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipelined_alu_dp #(.WIDTH(4), .PARITY_ODD(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .func_code(func_code),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_parity(out_parity), .out_err(out_err));
  pipelined_alu_dp #(.WIDTH(4), .PARITY_ODD(1'b0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready), .func_code(func_code),
    .a(a), .b(b), .out_valid(p_out_valid), .out_ready(out_ready), .out_result(p_out_result),
    .out_carry(p_out_carry), .out_zero(p_out_zero), .out_parity(p_out_parity), .out_err(p_out_err));
  pipelined_alu_dp #(.WIDTH(8), .PARITY_ODD(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .func_code(func_code),
    .a(a8), .b(b8), .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
    .out_carry(w_out_carry), .out_zero(w_out_zero), .out_parity(w_out_parity), .out_err(w_out_err));
  function automatic exp_t model(input logic [7:0] f, input logic [7:0] x, input logic [7:0] y, input int w);
    exp_t e;
    logic [8:0] s;
    logic [7:0] m;
    m = 8'hFF >> (8 - w);
    e.e = 0;
    case (f)
      8'h80: s = {1'b0, x} + {1'b0, y};
      8'h40: s = {1'b0, x} - {1'b0, y};
      8'h20: s = {1'b0, x ^ y};
      8'h10: s = {1'b0, x | y};
      8'h08: s = {1'b0, x & y};
      8'h04: s = {1'b0, ~(x | y)};
      8'h02: s = {1'b0, ~(x & y)};
      8'h01: s = {1'b0, ~(x ^ y)};
      default: begin s = {1'b0, x}; e.e = 1; end
    endcase
    e.r = s[7:0] & m;
    e.c = (f == 8'h80 || f == 8'h40) ? s[w] : 1'b0;
    e.z = e.r == 0;
    e.p = ~^e.r;
    return e;
  endfunction
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin bad++; $display("FAIL unexpected_output got=%h exp=none", out_result); end
      else begin
        e = q.pop_front();
        if ({out_result, out_carry, out_zero, out_parity, out_err} !== {e.r[3:0], e.c, e.z, e.p, e.e}) begin
          bad++;
          $display("FAIL w4_out got r=%h c=%b z=%b p=%b e=%b exp r=%h c=%b z=%b p=%b e=%b",
                   out_result, out_carry, out_zero, out_parity, out_err, e.r[3:0], e.c, e.z, e.p, e.e);
        end
        total++;
        if ({p_out_valid, p_out_result, p_out_zero, p_out_parity} !== {1'b1, e.r[3:0], e.z, ~e.p}) begin
          bad++;
          $display("FAIL even_parity got v=%b r=%h z=%b p=%b exp v=1 r=%h z=%b p=%b",
                   p_out_valid, p_out_result, p_out_zero, p_out_parity, e.r[3:0], e.z, ~e.p);
        end
      end
    end
    if (w_out_valid && out_ready) begin
      total++;
      if (q8.size() == 0) begin bad++; $display("FAIL unexpected_w8_output got=%h exp=none", w_out_result); end
      else begin
        e = q8.pop_front();
        if ({w_out_result, w_out_carry, w_out_zero, w_out_parity, w_out_err} !== {e.r, e.c, e.z, e.p, e.e}) begin
          bad++;
          $display("FAIL w8_out got r=%h c=%b z=%b p=%b e=%b exp r=%h c=%b z=%b p=%b e=%b",
                   w_out_result, w_out_carry, w_out_zero, w_out_parity, w_out_err, e.r, e.c, e.z, e.p, e.e);
        end
      end
    end
    if (in_valid && in_ready) q.push_back(model(func_code, {4'h0, a}, {4'h0, b}, 4));
    if (in_valid && w_in_ready) q8.push_back(model(func_code, a8, b8, 8));
  end
  task automatic send(input logic [7:0] f, input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    func_code = f; a = x; b = y; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin total++; bad++; $display("FAIL send_timeout got in_ready=0 exp 1"); end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 20) begin @(negedge clk); n++; end
    total++;
    if (q.size() != 0 || q8.size() != 0) begin bad++; $display("FAIL drain got pending=%0d exp 0", q.size() + q8.size()); end
    @(posedge clk); #1;
  endtask
  task automatic check_reset_state(input string tag);
    @(negedge clk);
    total++;
    if ({out_valid, out_result, out_carry, out_zero, out_parity, out_err, in_ready, w_out_valid, w_out_result} !== {1'b0, 4'h0, 5'b0, 1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL %s got v=%b r=%h c=%b z=%b p=%b e=%b rdy=%b w8v=%b w8r=%h exp all 0 with rdy=1",
               tag, out_valid, out_result, out_carry, out_zero, out_parity, out_err, in_ready, w_out_valid, w_out_result);
    end
  endtask
  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 1; func_code = 0; a = 0; b = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_reset_state("reset");
    @(posedge clk); #1;
  endtask
  task automatic test_add();
    send(8'h80, 4'b0101, 4'b1110);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early got v=%b exp 0", out_valid); end
    @(negedge clk);
    total++;
    if ({out_valid, out_result, out_carry, out_zero, out_parity} !== {1'b1, 4'b0011, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_latency got v=%b r=%b c=%b z=%b p=%b exp v=1 r=0011 c=1 z=0 p=1",
               out_valid, out_result, out_carry, out_zero, out_parity);
    end
    @(posedge clk); #1;
    drain();
  endtask
  task automatic test_back_to_back();
    send(8'h40, 4'b0101, 4'b1110);
    send(8'h20, 4'b0101, 4'b1110);
    send(8'h01, 4'b0101, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (i < 2)) begin bad++; $display("FAIL b2b_valid%0d got v=%b exp %b", i, out_valid, i < 2); end
    end
    @(posedge clk); #1;
    drain();
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    send(8'h10, 4'b0011, 4'b1001);
    send(8'h08, 4'b0111, 4'b1100);
    fork
      send(8'h02, 4'b1010, 4'b0110);
      begin
        logic [3:0] held;
        held = q[0].r[3:0];
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          total++;
          if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, held}) begin
            bad++;
            $display("FAIL hold%0d got v=%b rdy=%b r=%h exp v=1 rdy=0 r=%h", i, out_valid, in_ready, out_result, held);
          end
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
  endtask
  task automatic test_illegal();
    send(8'h00, 4'b1010, 4'b0110);
    send(8'hC0, 4'b1010, 4'b0110);
    send(8'h04, 4'b1010, 4'b0100);
    drain();
  endtask
  task automatic test_zero();
    send(8'h40, 4'b0011, 4'b0011);
    drain();
  endtask
  task automatic test_mid_reset();
    out_ready = 0;
    send(8'h80, 4'h1, 4'h1);
    send(8'h80, 4'h2, 4'h2);
    rst_n = 0;
    q.delete();
    q8.delete();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    check_reset_state("mid_reset");
    @(posedge clk); #1;
  endtask
  task automatic test_w8();
    a8 = 8'hFF; b8 = 8'h01;
    send(8'h80, 4'h0, 4'h0);
    a8 = 8'h3C; b8 = 8'hC5;
    send(8'h40, 4'h0, 4'h0);
    drain();
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_zero();
    test_mid_reset();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
